// File: rtl/spi_resp_pkg.sv
// Shared opcodes and FSM encoding for the SPI flash responder.
// Fast-read support (opcode 0x0B) is enabled by defining SPI_RESP_FAST_READ_EN.
package spi_resp_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_RDID      = 8'h9F;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam logic [4:0] ADDR_LAST_BIT  = 5'd23;
    localparam logic [4:0] BYTE_LAST_BIT  = 5'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchronizers for the SPI pins plus sck/cs_b edge detection.
// Latency: 2 clk to synchronized level, edge pulses one clk wide on the 2nd-stage change.
// Backpressure: none; free-running sampler.
module spi_resp_sync (
    input  logic clk,
    input  logic reset,
    input  logic cs_b_in,
    input  logic sck_in,
    input  logic mosi_in,
    output logic cs_b_s,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_s
);

    logic [1:0] cs_sync_q, cs_sync_d;
    logic [1:0] sck_sync_q, sck_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic       cs_prev_q, cs_prev_d;
    logic       sck_prev_q, sck_prev_d;

    always_comb begin
        cs_sync_d   = {cs_sync_q[0], cs_b_in};
        sck_sync_d  = {sck_sync_q[0], sck_in};
        mosi_sync_d = {mosi_sync_q[0], mosi_in};
        cs_prev_d   = cs_sync_q[1];
        sck_prev_d  = sck_sync_q[1];
    end

    // cs_b resets low so a select already held across reset never looks like a fresh fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q   <= 2'b00;
            sck_sync_q  <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
        end
    end

    assign cs_b_s   = cs_sync_q[1];
    assign cs_fall  = cs_prev_q & ~cs_sync_q[1];
    assign sck_rise = ~sck_prev_q & sck_sync_q[1];
    assign sck_fall = sck_prev_q & ~sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ, RDSR, RDID, WREN/WRDI; FAST_READ with SPI_RESP_FAST_READ_EN.
// Latency: ~3 clk from sck pin edge to response; memory read issued one clk after last address bit.
// Backpressure: none; memory must return data the clk after mem_rd_en.
module spi_flash_responder
    import spi_resp_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_b,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    input  logic              status_busy,
    output logic              wel
);

    logic cs_b_s, cs_fall, sck_rise, sck_fall, mosi_s;

    spi_resp_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .cs_b_in  (spi_cs_b),
        .sck_in   (spi_sck),
        .mosi_in  (spi_mosi),
        .cs_b_s   (cs_b_s),
        .cs_fall  (cs_fall),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .mosi_s   (mosi_s)
    );

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        op_q, op_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              wel_q, wel_d;
    logic              wel_set_q, wel_set_d;
    logic              wel_clr_q, wel_clr_d;

    logic [7:0] op_in;
    logic [7:0] byte_src;
    logic       is_read;

    assign op_in   = {cmd_q[6:0], mosi_s};
    assign is_read = (op_q == OP_READ) || (op_q == OP_FAST_READ);

    // Byte presented at each byte boundary; read data is already parked in tx_q by then.
    always_comb begin
        byte_src = tx_q;
        if (op_q == OP_RDID) begin
            case (id_idx_q)
                2'd0:    byte_src = JEDEC_ID[23:16];
                2'd1:    byte_src = JEDEC_ID[15:8];
                2'd2:    byte_src = JEDEC_ID[7:0];
                default: byte_src = 8'h00;
            endcase
        end else if (op_q == OP_RDSR) begin
            byte_src = {6'b0, wel_q, status_busy};
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        op_d       = op_q;
        mem_addr_d = mem_addr_q;
        rd_en_d    = 1'b0;
        rd_pend_d  = rd_en_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        id_idx_d   = id_idx_q;
        wel_d      = wel_q;
        wel_set_d  = wel_set_q;
        wel_clr_d  = wel_clr_q;

        if (rd_pend_q) begin
            tx_d = mem_rd_data;
        end

        if (cs_b_s) begin
            // Pending WREN/WRDI only survive if no sck rise followed the opcode.
            if (wel_set_q) wel_d = 1'b1;
            if (wel_clr_q) wel_d = 1'b0;
            wel_set_d = 1'b0;
            wel_clr_d = 1'b0;
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                        cmd_d     = 8'h00;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_d     = op_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == BYTE_LAST_BIT) begin
                            bit_cnt_d = 5'd0;
                            op_d      = op_in;
                            id_idx_d  = 2'd0;
                            case (op_in)
                                OP_READ:             state_d = ST_ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                                OP_FAST_READ:        state_d = ST_ADDR;
`endif
                                OP_RDID, OP_RDSR:    state_d = ST_DATA;
                                OP_WREN: begin
                                    state_d   = ST_IGNORE;
                                    wel_set_d = 1'b1;
                                end
                                OP_WRDI: begin
                                    state_d   = ST_IGNORE;
                                    wel_clr_d = 1'b1;
                                end
                                default:             state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        mem_addr_d = {mem_addr_q[ADDR_W-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == ADDR_LAST_BIT) begin
                            bit_cnt_d = 5'd0;
                            rd_en_d   = 1'b1;
                            state_d   = ST_DATA;
`ifdef SPI_RESP_FAST_READ_EN
                            if (op_q == OP_FAST_READ) state_d = ST_DUMMY;
`endif
                        end
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                ST_DUMMY: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == BYTE_LAST_BIT) begin
                            bit_cnt_d = 5'd0;
                            state_d   = ST_DATA;
                        end
                    end
                end
`endif
                ST_DATA: begin
                    if (sck_fall) begin
                        if (bit_cnt_q[2:0] == 3'd0) begin
                            miso_d = byte_src[7];
                            tx_d   = {byte_src[6:0], 1'b0};
                            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                    end
                    // Rise of the last bit of a byte: fetch the following byte.
                    if (sck_rise && bit_cnt_q[2:0] == 3'd0 && is_read) begin
                        rd_en_d    = 1'b1;
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
                ST_IGNORE: begin
                    if (sck_rise) begin
                        wel_set_d = 1'b0;
                        wel_clr_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        oe_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 5'd0;
            cmd_q      <= 8'h00;
            op_q       <= 8'h00;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            tx_q       <= 8'h00;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            id_idx_q   <= 2'd0;
            wel_q      <= 1'b0;
            wel_set_q  <= 1'b0;
            wel_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            op_q       <= op_d;
            mem_addr_q <= mem_addr_d;
            rd_en_q    <= rd_en_d;
            rd_pend_q  <= rd_pend_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            id_idx_q   <= id_idx_d;
            wel_q      <= wel_d;
            wel_set_q  <= wel_set_d;
            wel_clr_q  <= wel_clr_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = rd_en_q;
    assign wel         = wel_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master, byte-level response model, memory model.
// Exercises fast read when SPI_RESP_FAST_READ_EN is defined.
module tb_spi_flash_responder;

    localparam logic [23:0] JEDEC = 24'hEF4016;
    localparam int NONE = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_b, spi_sck, spi_mosi, status_busy;
    logic        spi_miso, spi_miso_oe, mem_rd_en, wel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'h00;

    spi_flash_responder dut (
        .clk         (clk),
        .reset       (reset),
        .spi_cs_b    (spi_cs_b),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .status_busy (status_busy),
        .wel         (wel)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  tx_buf   [0:15];
    logic [7:0]  rx_data  [0:15];
    logic [7:0]  exp_data [0:15];
    logic [15:0] rd_log [$];
    int n_chk = 0;
    int n_fail = 0;
    int bit_idx = 0;
    int data_start = NONE;
    bit chk_en = 1'b0;
    bit model_wel = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: registered read, data valid the clk after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
    end

    // Expected k-th response byte of a transaction, straight from the command semantics.
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [15:0] a, input int k);
        case (op)
            8'h9F:   model_byte = (k < 3) ? 8'(JEDEC >> (16 - 8 * k)) : 8'h00;
            8'h05:   model_byte = {6'b0, model_wel, status_busy};
            default: model_byte = mem[16'(a + 16'(k))];
        endcase
    endfunction

    // Compare process: the master samples miso on every sck rise.
    always @(posedge spi_sck) begin
        if (chk_en) begin
            if (bit_idx >= data_start) begin
                int d;
                d = bit_idx - data_start;
                chk("miso_oe_data", {31'b0, spi_miso_oe}, 32'd1);
                chk("miso_bit", {31'b0, spi_miso}, {31'b0, exp_data[d / 8][7 - (d % 8)]});
                rx_data[d / 8][7 - (d % 8)] = spi_miso;
            end else begin
                chk("miso_oe_quiet", {31'b0, spi_miso_oe}, 32'd0);
            end
        end
    end

    task automatic load_tx(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        for (int k = 0; k < 16; k++) tx_buf[k] = 8'h00;
        tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3;
    endtask

    task automatic spi_xfer(input int nbits, input int rst_at);
        logic [7:0]  op;
        logic [15:0] a;
        int          nreads;
        bit          aborted;
        op = tx_buf[0];
        a  = {tx_buf[2], tx_buf[3]};
        aborted = 1'b0;
        data_start = NONE;
        case (op)
            8'h9F, 8'h05: data_start = 8;
            8'h03:        data_start = 32;
`ifdef SPI_RESP_FAST_READ_EN
            8'h0B:        data_start = 40;
`endif
            default:      data_start = NONE;
        endcase
        for (int k = 0; k < 16; k++) begin
            exp_data[k] = model_byte(op, a, k);
            rx_data[k]  = 8'h00;
        end
        rd_log.delete();
        @(negedge clk);
        spi_cs_b = 1'b0;
        repeat (8) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                model_wel = 1'b0;
                data_start = NONE;
                aborted = 1'b1;
            end
            spi_mosi = tx_buf[i / 8][7 - (i % 8)];
            bit_idx = i;
            repeat (8) @(negedge clk);
            spi_sck = 1'b1;
            repeat (8) @(negedge clk);
            spi_sck = 1'b0;
        end
        chk_en = 1'b0;
        repeat (4) @(negedge clk);
        spi_cs_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("oe_off_after_cs", {31'b0, spi_miso_oe}, 32'd0);
        repeat (8) @(negedge clk);
        if (!aborted && nbits == 8 && op == 8'h06) model_wel = 1'b1;
        if (!aborted && nbits == 8 && op == 8'h04) model_wel = 1'b0;
        chk("wel", {31'b0, wel}, {31'b0, model_wel});
        nreads = 0;
        if (!aborted && data_start != NONE && (op == 8'h03 || op == 8'h0B) && nbits >= 32)
            nreads = 1 + ((nbits >= data_start) ? (nbits - data_start) / 8 : 0);
        chk("rd_count", rd_log.size(), nreads);
        for (int j = 0; j < nreads && j < rd_log.size(); j++)
            chk("rd_addr", {16'b0, rd_log[j]}, {16'b0, 16'(a + 16'(j))});
    endtask

    function automatic logic [15:0] log_at(input int j);
        log_at = (j < rd_log.size()) ? rd_log[j] : 16'hDEAD;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
        mem[16'h0000] = 8'h7E; mem[16'h0001] = 8'h11;
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h5A;
        mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'h99;
        mem[16'hFFFF] = 8'h3C;
        reset = 1'b1; spi_cs_b = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; status_busy = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
        chk("rst_miso", {31'b0, spi_miso}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_wel", {31'b0, wel}, 32'd0);

        // RDID with 4 response bytes
        load_tx(8'h9F, 8'h00, 8'h00, 8'h00);
        spi_xfer(40, -1);
        chk("rdid_b0", {24'b0, rx_data[0]}, 32'hEF);
        chk("rdid_b1", {24'b0, rx_data[1]}, 32'h40);
        chk("rdid_b2", {24'b0, rx_data[2]}, 32'h16);
        chk("rdid_b3", {24'b0, rx_data[3]}, 32'h00);

        // READ 0x000010, 3 bytes
        load_tx(8'h03, 8'h00, 8'h00, 8'h10);
        spi_xfer(56, -1);
        chk("read_b0", {24'b0, rx_data[0]}, 32'hA5);
        chk("read_b1", {24'b0, rx_data[1]}, 32'h5A);
        chk("read_b2", {24'b0, rx_data[2]}, 32'hC3);
        chk("read_last_addr", {16'b0, log_at(3)}, 32'h13);

        // READ across the top of the address space
        load_tx(8'h03, 8'h00, 8'hFF, 8'hFF);
        spi_xfer(48, -1);
        chk("wrap_b0", {24'b0, rx_data[0]}, 32'h3C);
        chk("wrap_b1", {24'b0, rx_data[1]}, 32'h7E);
        chk("wrap_a0", {16'b0, log_at(0)}, 32'hFFFF);
        chk("wrap_a1", {16'b0, log_at(1)}, 32'h0000);

        // WREN then RDSR with busy, WRDI then RDSR
        status_busy = 1'b1;
        load_tx(8'h06, 8'h00, 8'h00, 8'h00);
        spi_xfer(8, -1);
        chk("wren_lit", {31'b0, wel}, 32'd1);
        load_tx(8'h05, 8'h00, 8'h00, 8'h00);
        spi_xfer(16, -1);
        chk("rdsr_wel1", {24'b0, rx_data[0]}, 32'h03);
        load_tx(8'h04, 8'h00, 8'h00, 8'h00);
        spi_xfer(8, -1);
        load_tx(8'h05, 8'h00, 8'h00, 8'h00);
        spi_xfer(24, -1);
        chk("rdsr_wel0_b0", {24'b0, rx_data[0]}, 32'h01);
        chk("rdsr_wel0_b1", {24'b0, rx_data[1]}, 32'h01);

        // WREN not ending on the byte boundary has no effect
        load_tx(8'h06, 8'h00, 8'h00, 8'h00);
        spi_xfer(9, -1);
        chk("wren_9bits", {31'b0, wel}, 32'd0);
        spi_xfer(16, -1);
        chk("wren_16bits", {31'b0, wel}, 32'd0);
        spi_xfer(8, -1);

        // READ aborted mid-address, then RDID
        load_tx(8'h03, 8'h00, 8'h01, 8'h00);
        spi_xfer(20, -1);
        load_tx(8'h9F, 8'h00, 8'h00, 8'h00);
        spi_xfer(32, -1);
        chk("after_abort_b0", {24'b0, rx_data[0]}, 32'hEF);
        chk("after_abort_b2", {24'b0, rx_data[2]}, 32'h16);

        // RDID aborted mid-data byte
        spi_xfer(12, -1);

        // Reset mid-transfer with wel set; response must stay off until a fresh select
        spi_xfer(24, 12);
        chk("rst_mid_wel", {31'b0, wel}, 32'd0);
        spi_xfer(32, -1);
        chk("post_rst_b1", {24'b0, rx_data[1]}, 32'h40);

        // FAST_READ 0x000000 with one dummy byte
        load_tx(8'h0B, 8'h00, 8'h00, 8'h00);
        spi_xfer(56, -1);
`ifdef SPI_RESP_FAST_READ_EN
        chk("fast_b0", {24'b0, rx_data[0]}, 32'h7E);
        chk("fast_b1", {24'b0, rx_data[1]}, 32'h11);
`else
        chk("fast_off_reads", rd_log.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the width of the backing-memory address; the low ADDR_W bits of the 24-bit SPI address are used.
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4016, meaning the three bytes returned by opcode 0x9F, MSB byte first.
REQ-003 SHALL have port clk, input, 1 bit: the 48 MHz system clock; the block has one clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port spi_cs_b, input, 1 bit: chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_sck, input, 1 bit: SPI mode-0 serial clock; its frequency is at most clk/8.
REQ-007 SHALL have port spi_mosi, input, 1 bit: data from the SPI master.
REQ-008 SHALL have port spi_miso, output, 1 bit: data to the SPI master.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit: output enable for spi_miso; the top level builds the tristate.
REQ-010 SHALL have port mem_addr, output, ADDR_W bits: backing-memory read address.
REQ-011 SHALL have port mem_rd_en, output, 1 bit: read strobe, a one-clk pulse.
REQ-012 SHALL have port mem_rd_data, input, 8 bits: read data, valid on the clk cycle after mem_rd_en.
REQ-013 SHALL have port status_busy, input, 1 bit: reported as status bit 0.
REQ-014 SHALL have port wel, output, 1 bit: the write-enable latch.

Function
REQ-015 SHALL pass spi_cs_b, spi_sck and spi_mosi through 2-flop synchronizers, and SHALL detect sck rise and fall edges on the synchronized signals.
REQ-016 SHALL sample mosi on each sck rise and shift it in MSB first; miso SHALL change only on an sck fall.
REQ-017 SHALL use the state machine IDLE, CMD, ADDR, DUMMY, DATA, IGNORE:
- IDLE goes to CMD on cs_b falling.
- In CMD, after the 8th rising edge: 0x03 goes to ADDR; 0x9F and 0x05 go to DATA; 0x06 sets wel and goes to IGNORE; 0x04 clears wel and goes to IGNORE; any other opcode goes to IGNORE.
- ADDR goes to DATA after 24 rising edges.
REQ-018 In DATA, spi_miso_oe SHALL be 1 and SHALL drive the first bit (MSB) on the sck fall that follows the last command or address bit.
REQ-019 For 0x03, SHALL pulse mem_rd_en with mem_addr equal to the address on the clk after the 24th address bit, and SHALL load mem_rd_data into the transmit shifter before the next sck fall.
REQ-020 For 0x03, SHALL prefetch the next byte by pulsing mem_rd_en on the rising edge of bit 0 of the current byte; the address SHALL increment by 1 per byte and wrap from 2^ADDR_W-1 to 0.
REQ-021 For 0x9F, SHALL send the 3 JEDEC_ID bytes and then repeat 0x00.
REQ-022 For 0x05, SHALL repeat {6'b0, wel, status_busy}; this value SHALL be re-sampled at each byte boundary.
REQ-023 On cs_b high in any state, SHALL go to IDLE and SHALL deassert spi_miso_oe within 3 clk cycles of the pin edge; a partial byte SHALL be discarded with no side effects.
REQ-024 0x06 and 0x04 SHALL take effect only if cs_b rises exactly on a byte boundary after 8 bits; otherwise wel is unchanged.
REQ-025 In IDLE, CMD, ADDR and IGNORE, spi_miso_oe SHALL be 0.

Reset
REQ-026 On reset: state IDLE, wel 0, spi_miso_oe 0, spi_miso 0, mem_rd_en 0, mem_addr 0, and shifters and counters 0.
REQ-027 Reset asserted mid-transfer SHALL abort it, and the block SHALL then wait for a fresh cs_b falling edge.

Configuration
REQ-028 With macro SPI_RESP_FAST_READ_EN defined, opcode 0x0B SHALL be decoded as: ADDR (24 bits), then DUMMY (8 sck cycles with miso_oe 0), then DATA as for 0x03.
REQ-029 Without SPI_RESP_FAST_READ_EN, 0x0B SHALL go to IGNORE, and no DUMMY logic SHALL be synthesized.

Structure
REQ-030 SHALL place the opcode constants (0x03, 0x05, 0x06, 0x04, 0x9F, 0x0B) and the state encoding in the shared package spi_resp_pkg.
REQ-031 SHALL instantiate one sub-module, spi_resp_sync, which contains the 2-flop synchronizer and the sck edge detector.

Verification
REQ-032 Reset, then send 0x9F with 4 dummy bytes: miso returns EF 40 16 00.
REQ-033 Send 0x03 000010 and read 3 bytes with memory [0x10..0x12] = A5 5A C3: miso returns A5 5A C3, and mem_rd_en pulses 3 or 4 times at addresses 0x10, 0x11, 0x12 (0x13).
REQ-034 Send 0x03 00FFFF with ADDR_W=16 and read 2 bytes: reads hit 0xFFFF, then 0x0000.
REQ-035 Send 0x06 with cs_b high, then 0x05 with status_busy=1: status byte is 0x03; sending 0x04 and then 0x05 gives 0x01.
REQ-036 Send 0x03 with cs_b raised after 12 address bits, then 0x9F: miso_oe is low within 3 clk cycles and the 0x9F response is correct.
REQ-037 With the macro defined, send 0x0B 000000 plus 1 dummy byte and memory[0]=0x7E: first data byte is 0x7E; without the macro, miso_oe stays 0.
